// File: rtl/shift_engine_if.sv
// shift_engine bus: load/start handshake and register outputs.
// Driver side is master, the shift unit is slave.
interface shift_engine_if #(
  parameter int WIDTH = 14,
  parameter int AMT_W = 4
);
  logic [WIDTH-1:0] d;
  logic             load;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [1:0]       mode;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output d, load, start, amount, mode, serial_in,
    input  q, serial_out, busy, done
  );

  modport slave (
    input  d, load, start, amount, mode, serial_in,
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/shift_engine.sv
// Multi-bit shift unit: parallel load, then n single-bit
// shifts in LSL/LSR/ASR/ROL with start/busy/done handshake.
module shift_engine #(
  parameter int WIDTH = 14,
  parameter int AMT_W = 4
) (
  input logic           clock,
  input logic           reset_n,
  shift_engine_if.slave bus
);

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] q_r;
  logic             so_r;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] sh_q;
  logic             sh_out;
  logic             busy_c;
  logic             done_c;
  logic             accept;

  assign accept = bus.start && !bus.load;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nx = (bus.amount != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (cnt == AMT_W'(1)) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy_c = (state == S_SHIFT);
    done_c = (state == S_DONE);
  end

  // One-bit shift result and leaving bit for the latched mode
  always_comb begin
    sh_q   = q_r;
    sh_out = 1'b0;
    unique case (1'b1)
      (mode_r == M_LSL): begin
        sh_q   = {q_r[WIDTH-2:0], bus.serial_in};
        sh_out = q_r[WIDTH-1];
      end
      (mode_r == M_LSR): begin
        sh_q   = {bus.serial_in, q_r[WIDTH-1:1]};
        sh_out = q_r[0];
      end
      (mode_r == M_ASR): begin
        sh_q   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        sh_out = q_r[0];
      end
      (mode_r == M_ROL): begin
        sh_q   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        sh_out = q_r[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Datapath: load in IDLE, latch op on accept, shift in SHIFT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_r    <= '0;
      so_r   <= 1'b0;
      cnt    <= '0;
      mode_r <= M_LSL;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.load) begin
            q_r  <= bus.d;
            so_r <= 1'b0;
          end else if (bus.start) begin
            mode_r <= bus.mode;
            cnt    <= bus.amount;
          end
        end
        S_SHIFT: begin
          q_r  <= sh_q;
          so_r <= sh_out;
          cnt  <= cnt - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.serial_out = so_r;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule

// File: tb/tb_shift_engine.sv
// Testbench for shift_engine: directed table, corner
// sequences and randomized ops against an arithmetic model.
module tb_shift_engine;

  localparam int W = 14;
  localparam int A = 4;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  shift_engine_if #(.WIDTH(W), .AMT_W(A)) bus ();

  shift_engine #(.WIDTH(W), .AMT_W(A)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   mode;
    int           amt;
    logic         sin;
    logic [W-1:0] exp_q;
    logic         exp_so;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Reference: apply the mode's rule amt times with plain arithmetic
  task automatic model(input logic [W-1:0] q0,
                       input logic so0,
                       input logic [1:0] m,
                       input int amt,
                       input logic sin,
                       output logic [W-1:0] qo,
                       output logic soo);
    int v;
    int top;
    int mask;
    int o;
    mask = (1 << W) - 1;
    top  = 1 << (W - 1);
    v    = int'(q0);
    o    = int'(so0);
    for (int i = 0; i < amt; i++) begin
      case (m)
        2'd0: begin
          o = (v >> (W - 1)) & 1;
          v = ((v * 2) + int'(sin)) & mask;
        end
        2'd1: begin
          o = v & 1;
          v = (v / 2) + (int'(sin) * top);
        end
        2'd2: begin
          o = v & 1;
          v = (v / 2) + (v & top);
        end
        default: begin
          o = (v >> (W - 1)) & 1;
          v = ((v * 2) + o) & mask;
        end
      endcase
    end
    qo  = W'(v);
    soo = o[0];
  endtask

  task automatic do_load(input logic [W-1:0] dv);
    @(negedge clock);
    bus.d    = dv;
    bus.load = 1'b1;
    @(posedge clock);
    #1;
    bus.load = 1'b0;
    check("load_q", 32'(bus.q), 32'(dv));
  endtask

  // Start an op, scramble mode/amount and pulse loads while it
  // runs, then report final q/serial_out and handshake timing.
  task automatic run_op(input logic [1:0] m,
                        input int amt,
                        input logic sin,
                        input string name,
                        output logic [W-1:0] qo,
                        output logic soo);
    int cyc;
    int bcnt;
    @(negedge clock);
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.amount    = A'(amt);
    bus.serial_in = sin;
    @(posedge clock);
    #1;
    bus.start  = 1'b0;
    bus.mode   = ~m;
    bus.amount = A'(amt + 5);
    cyc  = 0;
    bcnt = 0;
    while (!bus.done && cyc < amt + 4) begin
      if (bus.busy) bcnt++;
      bus.load = 1'b1;
      bus.d    = W'($urandom);
      @(posedge clock);
      #1;
      cyc++;
    end
    bus.load = 1'b0;
    check({name, "_done_seen"}, 32'(bus.done), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'(amt));
    check({name, "_busy_cycles"}, 32'(bcnt), 32'(amt));
    qo  = bus.q;
    soo = bus.serial_out;
  endtask

  task automatic finish_op(input string name);
    @(posedge clock);
    #1;
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  vec_t         vecs[7];
  logic [W-1:0] q_got;
  logic         so_got;
  logic [W-1:0] q_ref;
  logic         so_ref;
  logic         seen;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.d = '0; bus.load = 0; bus.start = 0;
    bus.amount = '0; bus.mode = '0; bus.serial_in = 0;

    vecs[0] = '{14'h0001, 2'd0, 3,  1'b0, 14'h0008, 1'b0};
    vecs[1] = '{14'h2000, 2'd2, 2,  1'b0, 14'h3800, 1'b0};
    vecs[2] = '{14'h2001, 2'd3, 1,  1'b0, 14'h0003, 1'b1};
    vecs[3] = '{14'h2001, 2'd3, 14, 1'b0, 14'h2001, 1'b1};
    vecs[4] = '{14'h0000, 2'd1, 4,  1'b1, 14'h3C00, 1'b0};
    vecs[5] = '{14'h1ABC, 2'd0, 0,  1'b0, 14'h1ABC, 1'b0};
    vecs[6] = '{14'h1ABC, 2'd0, 15, 1'b0, 14'h0000, 1'b0};

    reset_n = 1'b0;
    #12;
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_so", 32'(bus.serial_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_load(vecs[i].d);
      run_op(vecs[i].mode, vecs[i].amt, vecs[i].sin,
             $sformatf("vec%0d", i), q_got, so_got);
      check($sformatf("vec%0d_q", i), 32'(q_got),
            32'(vecs[i].exp_q));
      check($sformatf("vec%0d_so", i), 32'(so_got),
            32'(vecs[i].exp_so));
      finish_op($sformatf("vec%0d", i));
    end

    // load and start together: load wins, no op starts
    @(negedge clock);
    bus.d = 14'h0005; bus.load = 1; bus.start = 1;
    bus.amount = 4'd2;
    @(posedge clock);
    #1;
    bus.load = 0; bus.start = 0;
    check("prio_q", 32'(bus.q), 32'h5);
    check("prio_busy", 32'(bus.busy), 32'd0);
    check("prio_done", 32'(bus.done), 32'd0);
    @(posedge clock);
    #1;
    check("prio_busy2", 32'(bus.busy), 32'd0);
    check("prio_done2", 32'(bus.done), 32'd0);

    // start held through DONE: ignored there, accepted in IDLE
    do_load(14'h0001);
    run_op(2'd0, 1, 1'b0, "retrig", q_got, so_got);
    check("retrig_q", 32'(q_got), 32'h2);
    bus.start = 1; bus.mode = 2'd0; bus.amount = 4'd1;
    @(posedge clock);
    #1;
    check("retrig_ign_busy", 32'(bus.busy), 32'd0);
    check("retrig_ign_done", 32'(bus.done), 32'd0);
    @(posedge clock);
    #1;
    bus.start = 0;
    check("retrig_acc_busy", 32'(bus.busy), 32'd1);
    @(posedge clock);
    #1;
    check("retrig2_done", 32'(bus.done), 32'd1);
    check("retrig2_q", 32'(bus.q), 32'h4);
    @(posedge clock);
    #1;

    // asynchronous reset in the middle of SHIFT
    do_load(14'h0001);
    @(negedge clock);
    bus.start = 1; bus.mode = 2'd0;
    bus.amount = 4'd3; bus.serial_in = 0;
    @(posedge clock);
    #1;
    bus.start = 0;
    @(posedge clock);
    #3;
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_q", 32'(bus.q), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);

    // randomized operations against the model
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] dv;
      logic [1:0]   m;
      int           amt;
      logic         sin;
      dv  = W'($urandom);
      m   = 2'($urandom_range(0, 3));
      amt = $urandom_range(0, 15);
      sin = 1'($urandom);
      do_load(dv);
      model(dv, 1'b0, m, amt, sin, q_ref, so_ref);
      run_op(m, amt, sin, $sformatf("rnd%0d", k),
             q_got, so_got);
      check($sformatf("rnd%0d_q", k), 32'(q_got), 32'(q_ref));
      check($sformatf("rnd%0d_so", k), 32'(so_got),
            32'(so_ref));
      finish_op($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
